traffic_junction: RTL and testbench

Timed two-road UK traffic-light controller with a pedestrian crossing phase. It is the parametrised successor to the single-head, one-step-per-clock sequencer. It drives two signal heads (road A, road B) through the full UK sequence, holding each phase for a programmable number of clock cycles. It enforces an all-red clearance between roads and inserts a walk phase on request. It sits between the board clock and the LED/lamp drivers.

---
 rtl/traffic_junction.sv | 213 +++++++++++++++++++++
 tb/tb_traffic_junction.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_junction.sv
// traffic_junction
//
// Timed two-road traffic-light controller with a pedestrian walk phase.
// Drives two signal heads (road A, road B) through the UK sequence
// red+amber -> green -> amber -> all-red clearance. Each phase is held
// for a programmable number of enabled clock cycles. After each clearance
// phase a walk phase is inserted if a pedestrian request is outstanding.
//
// Parameters:
//   CNT_W        width of the phase timer (every T_* <= 2^CNT_W - 1)
//   T_RED_AMBER  cycles in red+amber before green
//   T_GREEN      cycles in green
//   T_AMBER      cycles in amber-only
//   T_ALL_RED    cycles of all-red clearance after each amber
//   T_WALK       cycles of pedestrian walk (all vehicle heads red)
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   enable       1 = run, 0 = freeze state/timer/lamps
//   ped_req      pedestrian button
//   a_red, a_amber, a_green   road A lamps (registered)
//   b_red, b_amber, b_green   road B lamps (registered)
//   walk         pedestrian walk lamp (registered)
//   ped_pending  latched, not-yet-served pedestrian request
//
// All outputs are registered and decoded from the next state, so the lamps
// change on the same edge as the state and have no combinational path
// from any input.

module traffic_junction #(
    parameter int CNT_W       = 8,
    parameter int T_RED_AMBER = 2,
    parameter int T_GREEN     = 20,
    parameter int T_AMBER     = 3,
    parameter int T_ALL_RED   = 2,
    parameter int T_WALK      = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ped_req,
    output logic a_red,
    output logic a_amber,
    output logic a_green,
    output logic b_red,
    output logic b_amber,
    output logic b_green,
    output logic walk,
    output logic ped_pending
);

    typedef enum logic [3:0] {
        A_RA   = 4'd0,
        A_GO   = 4'd1,
        A_AMB  = 4'd2,
        CLR_A  = 4'd3,
        WALK_A = 4'd4,
        B_RA   = 4'd5,
        B_GO   = 4'd6,
        B_AMB  = 4'd7,
        CLR_B  = 4'd8,
        WALK_B = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] LD_RED_AMBER = CNT_W'(T_RED_AMBER - 1);
    localparam logic [CNT_W-1:0] LD_GREEN     = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_AMBER     = CNT_W'(T_AMBER - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED   = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_WALK      = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             state_legal;
    logic             walk_req;
    logic             in_walk;
    logic             enter_walk;
    logic             pend_nxt;
    logic             a_red_nxt, a_amber_nxt, a_green_nxt;
    logic             b_red_nxt, b_amber_nxt, b_green_nxt;
    logic             walk_nxt;

    // Reload value for the state being entered.
    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        logic [CNT_W-1:0] v;
        v = LD_ALL_RED;
        case (s)
            A_RA, B_RA:     v = LD_RED_AMBER;
            A_GO, B_GO:     v = LD_GREEN;
            A_AMB, B_AMB:   v = LD_AMBER;
            CLR_A, CLR_B:   v = LD_ALL_RED;
            WALK_A, WALK_B: v = LD_WALK;
            default:        v = LD_ALL_RED;
        endcase
        return v;
    endfunction

    // Next state and timer.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        state_legal = 1'b1;
        walk_req    = ped_pending | ped_req;

        case (state)
            A_RA, A_GO, A_AMB, CLR_A, WALK_A,
            B_RA, B_GO, B_AMB, CLR_B, WALK_B: state_legal = 1'b1;
            default:                          state_legal = 1'b0;
        endcase

        if (!state_legal) begin
            // Recover from a corrupted encoding into a safe all-red phase.
            state_nxt = CLR_B;
            timer_nxt = LD_ALL_RED;
        end else if (enable) begin
            if (timer == '0) begin
                case (state)
                    A_RA:    state_nxt = A_GO;
                    A_GO:    state_nxt = A_AMB;
                    A_AMB:   state_nxt = CLR_A;
                    CLR_A:   state_nxt = walk_req ? WALK_A : B_RA;
                    WALK_A:  state_nxt = B_RA;
                    B_RA:    state_nxt = B_GO;
                    B_GO:    state_nxt = B_AMB;
                    B_AMB:   state_nxt = CLR_B;
                    CLR_B:   state_nxt = walk_req ? WALK_B : A_RA;
                    WALK_B:  state_nxt = A_RA;
                    default: state_nxt = CLR_B;
                endcase
                timer_nxt = load_val(state_nxt);
            end else begin
                timer_nxt = timer - ONE;
            end
        end
    end

    // Pedestrian latch: presses during walk are ignored, and the clear on
    // walk entry wins over a press in the same cycle.
    always_comb begin
        in_walk    = (state == WALK_A) || (state == WALK_B);
        enter_walk = ((state_nxt == WALK_A) || (state_nxt == WALK_B)) && !in_walk;
        pend_nxt   = ped_pending;
        if (ped_req && !in_walk) begin
            pend_nxt = 1'b1;
        end
        if (enter_walk) begin
            pend_nxt = 1'b0;
        end
    end

    // Lamp decode of the next state; both heads default to red only.
    always_comb begin
        a_red_nxt   = 1'b1;
        a_amber_nxt = 1'b0;
        a_green_nxt = 1'b0;
        b_red_nxt   = 1'b1;
        b_amber_nxt = 1'b0;
        b_green_nxt = 1'b0;
        walk_nxt    = 1'b0;
        case (state_nxt)
            A_RA:   a_amber_nxt = 1'b1;
            A_GO: begin
                a_red_nxt   = 1'b0;
                a_green_nxt = 1'b1;
            end
            A_AMB: begin
                a_red_nxt   = 1'b0;
                a_amber_nxt = 1'b1;
            end
            B_RA:   b_amber_nxt = 1'b1;
            B_GO: begin
                b_red_nxt   = 1'b0;
                b_green_nxt = 1'b1;
            end
            B_AMB: begin
                b_red_nxt   = 1'b0;
                b_amber_nxt = 1'b1;
            end
            WALK_A, WALK_B: walk_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLR_B;
            timer       <= LD_ALL_RED;
            a_red       <= 1'b1;
            a_amber     <= 1'b0;
            a_green     <= 1'b0;
            b_red       <= 1'b1;
            b_amber     <= 1'b0;
            b_green     <= 1'b0;
            walk        <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            a_red       <= a_red_nxt;
            a_amber     <= a_amber_nxt;
            a_green     <= a_green_nxt;
            b_red       <= b_red_nxt;
            b_amber     <= b_amber_nxt;
            b_green     <= b_green_nxt;
            walk        <= walk_nxt;
            ped_pending <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_junction.sv
// tb_traffic_junction
//
// Directed bench for traffic_junction with default parameters. Each driver
// step applies one cycle of inputs and pushes the hand-derived lamp and
// ped_pending values expected after that edge. An independent monitor pops
// one entry after every edge and compares, and also checks the lamp safety
// rules on every observed cycle.

module tb_traffic_junction;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic ped_req = 1'b0;
    logic a_red, a_amber, a_green;
    logic b_red, b_amber, b_green;
    logic walk, ped_pending;

    // {a_red,a_amber,a_green, b_red,b_amber,b_green, walk}
    localparam logic [6:0] L_ARA  = 7'b110_100_0;
    localparam logic [6:0] L_AGO  = 7'b001_100_0;
    localparam logic [6:0] L_AAMB = 7'b010_100_0;
    localparam logic [6:0] L_ALLR = 7'b100_100_0;
    localparam logic [6:0] L_WALK = 7'b100_100_1;
    localparam logic [6:0] L_BRA  = 7'b100_110_0;
    localparam logic [6:0] L_BGO  = 7'b100_001_0;
    localparam logic [6:0] L_BAMB = 7'b100_010_0;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int step_no = 0;
    bit seen = 1'b0;
    string test_name = "none";

    traffic_junction dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ped_req     (ped_req),
        .a_red       (a_red),
        .a_amber     (a_amber),
        .a_green     (a_green),
        .b_red       (b_red),
        .b_amber     (b_amber),
        .b_green     (b_green),
        .walk        (walk),
        .ped_pending (ped_pending)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step(input logic en, input logic req, input logic r,
                        input logic [6:0] lamps, input logic pp);
        @(negedge clk);
        enable  = en;
        ped_req = req;
        rst     = r;
        exp_q.push_back({lamps, pp});
    endtask

    task automatic run(input int n, input logic en, input logic req,
                       input logic [6:0] lamps, input logic pp);
        for (int i = 0; i < n; i++) begin
            step(en, req, 1'b0, lamps, pp);
        end
    endtask

    task automatic reset_step();
        step(1'b1, 1'b0, 1'b1, L_ALLR, 1'b0);
    endtask

    // A legal head shows exactly one of red / red+amber / green / amber.
    function automatic bit head_ok(input logic [2:0] h);
        return (h == 3'b100) || (h == 3'b110) || (h == 3'b001) || (h == 3'b010);
    endfunction

    // Scoreboard monitor
    always @(posedge clk) begin
        logic [7:0] exp_v;
        logic [7:0] got_v;
        #1;
        got_v = {a_red, a_amber, a_green, b_red, b_amber, b_green, walk, ped_pending};
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            step_no++;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s step %0d outputs: got %b expected %b",
                         test_name, step_no, got_v, exp_v);
            end
            seen = 1'b1;
        end
        if (seen) begin
            checks++;
            if (!head_ok({a_red, a_amber, a_green}) || !head_ok({b_red, b_amber, b_green})) begin
                errors++;
                $display("FAIL %s step %0d head_aspect: got a=%b b=%b expected one legal aspect each",
                         test_name, step_no, {a_red, a_amber, a_green}, {b_red, b_amber, b_green});
            end
            checks++;
            if ((a_red !== 1'b1 || a_amber || a_green) && (b_red !== 1'b1 || b_amber || b_green)) begin
                errors++;
                $display("FAIL %s step %0d both_non_red: got a=%b b=%b expected one road red only",
                         test_name, step_no, {a_red, a_amber, a_green}, {b_red, b_amber, b_green});
            end
            checks++;
            if (walk && ({a_red, a_amber, a_green, b_red, b_amber, b_green} !== 6'b100_100)) begin
                errors++;
                $display("FAIL %s step %0d walk_safety: got walk=1 a=%b b=%b expected both red only",
                         test_name, step_no, {a_red, a_amber, a_green}, {b_red, b_amber, b_green});
            end
        end
    end

    initial begin
        // Free run: first green at 4th edge, 20 cycles green, 54-cycle period.
        test_name = "free_run";
        reset_step();
        run(1, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(20, 1, 0, L_AGO, 0);
        run(3, 1, 0, L_AAMB, 0);
        run(2, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_BRA, 0);
        run(20, 1, 0, L_BGO, 0);
        run(3, 1, 0, L_BAMB, 0);
        run(2, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(2, 1, 0, L_AGO, 0);

        // One-cycle press during A_GO is latched, served as WALK_A, cleared on entry.
        test_name = "ped_pulse";
        reset_step();
        run(1, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(5, 1, 0, L_AGO, 0);
        run(1, 1, 1, L_AGO, 1);
        run(14, 1, 0, L_AGO, 1);
        run(3, 1, 0, L_AAMB, 1);
        run(2, 1, 0, L_ALLR, 1);
        run(10, 1, 0, L_WALK, 0);
        run(2, 1, 0, L_BRA, 0);
        run(20, 1, 0, L_BGO, 0);
        run(3, 1, 0, L_BAMB, 0);
        run(2, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);

        // Press held through WALK_A: ignored during walk, no second walk;
        // a later fresh press is served as WALK_B.
        test_name = "ped_held";
        reset_step();
        run(1, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(20, 1, 0, L_AGO, 0);
        run(3, 1, 1, L_AAMB, 1);
        run(2, 1, 1, L_ALLR, 1);
        run(10, 1, 1, L_WALK, 0);
        run(2, 1, 0, L_BRA, 0);
        run(20, 1, 0, L_BGO, 0);
        run(3, 1, 0, L_BAMB, 0);
        run(2, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(20, 1, 0, L_AGO, 0);
        run(3, 1, 0, L_AAMB, 0);
        run(2, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_BRA, 0);
        run(3, 1, 0, L_BGO, 0);
        run(1, 1, 1, L_BGO, 1);
        run(16, 1, 0, L_BGO, 1);
        run(3, 1, 0, L_BAMB, 1);
        run(2, 1, 0, L_ALLR, 1);
        run(10, 1, 0, L_WALK, 0);
        run(2, 1, 0, L_ARA, 0);

        // Press only on the CLR_A exit cycle still enters WALK_A.
        test_name = "ped_exit_cycle";
        reset_step();
        run(1, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(20, 1, 0, L_AGO, 0);
        run(3, 1, 0, L_AAMB, 0);
        run(2, 1, 0, L_ALLR, 0);
        run(1, 1, 1, L_WALK, 0);
        run(9, 1, 0, L_WALK, 0);
        run(2, 1, 0, L_BRA, 0);
        run(2, 1, 0, L_BGO, 0);

        // Freeze mid-green for 15 cycles; press during freeze still latches.
        test_name = "freeze";
        reset_step();
        run(1, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(8, 1, 0, L_AGO, 0);
        run(4, 0, 0, L_AGO, 0);
        run(1, 0, 1, L_AGO, 1);
        run(10, 0, 0, L_AGO, 1);
        run(12, 1, 0, L_AGO, 1);
        run(3, 1, 0, L_AAMB, 1);
        run(2, 1, 0, L_ALLR, 1);
        run(10, 1, 0, L_WALK, 0);
        run(2, 1, 0, L_BRA, 0);

        // Reset during B_GO (with a press) and during WALK_B (with enable low).
        test_name = "mid_reset";
        reset_step();
        run(1, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(20, 1, 0, L_AGO, 0);
        run(3, 1, 0, L_AAMB, 0);
        run(2, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_BRA, 0);
        run(5, 1, 0, L_BGO, 0);
        step(1, 1, 1, L_ALLR, 0);
        run(1, 1, 0, L_ALLR, 0);
        run(1, 1, 1, L_WALK, 0);
        run(4, 1, 0, L_WALK, 0);
        step(0, 0, 1, L_ALLR, 0);
        run(1, 1, 0, L_ALLR, 0);
        run(2, 1, 0, L_ARA, 0);
        run(1, 1, 0, L_AGO, 0);

        // Drain: every pushed expectation must have been consumed.
        test_name = "drain";
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue: got %0d entries left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
